// File: rtl/conv_mult_sched.sv
// conv_mult_sched: sequences one multiply core across a full feature map for
// a single kernel pass. Output positions are walked in raster order, each
// kernel window is requested from the upstream fetch unit, a shadow pipe of
// valid bits and coordinates tracks which core slots hold real windows, and
// every core result is registered with its output coordinates into a
// valid/ready output stage.
// Optional feature: define SCHED_PERF_CNT_EN to add the 32-bit ostall_cnt
// output, a saturating count of busy cycles lost to output back-pressure.
module conv_mult_sched #(
    parameter int pDATA_W   = 8,
    parameter int pKERNEL_X = 3,
    parameter int pKERNEL_Y = 3,
    parameter int pIMG_W    = 32,
    parameter int pIMG_H    = 32,
    parameter int pSTRIDE   = 1,
    parameter int pCORE_LAT = 3
) (
    input  logic                                           iclk,
    input  logic                                           irst,
    input  logic                                           istart,
    output logic                                           obusy,
    output logic                                           odone,
    output logic [((pIMG_W > 1) ? $clog2(pIMG_W) : 1)-1:0] owin_x,
    output logic [((pIMG_H > 1) ? $clog2(pIMG_H) : 1)-1:0] owin_y,
    output logic                                           owin_req,
    input  logic                                           iwin_rdy,
    output logic                                           ocalc_en,
    input  logic [pDATA_W-1:0]                             icore_data,
    output logic                                           oout_valid,
    input  logic                                           iout_ready,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0]                                    ostall_cnt,
`endif
    output logic [pDATA_W-1:0]                             oout_data,
    output logic [((pIMG_W > 1) ? $clog2(pIMG_W) : 1)-1:0] oout_x,
    output logic [((pIMG_H > 1) ? $clog2(pIMG_H) : 1)-1:0] oout_y
);

    localparam int XW    = (pIMG_W > 1) ? $clog2(pIMG_W) : 1;
    localparam int YW    = (pIMG_H > 1) ? $clog2(pIMG_H) : 1;
    // Floor division drops trailing columns/rows that cannot hold a full window.
    localparam int OUT_W = (pIMG_W - pKERNEL_X) / pSTRIDE + 1;
    localparam int OUT_H = (pIMG_H - pKERNEL_Y) / pSTRIDE + 1;

    localparam logic [XW-1:0] LAST_X = XW'(OUT_W - 1);
    localparam logic [YW-1:0] LAST_Y = YW'(OUT_H - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [XW-1:0]        ox_q;
    logic [XW-1:0]        ox_d;
    logic [YW-1:0]        oy_q;
    logic [YW-1:0]        oy_d;

    logic [pCORE_LAT-1:0] pipeValid_q;
    logic [XW-1:0]        pipeX_q [pCORE_LAT];
    logic [YW-1:0]        pipeY_q [pCORE_LAT];

    logic                 outValid_q;
    logic [pDATA_W-1:0]   outData_q;
    logic [XW-1:0]        outX_q;
    logic [YW-1:0]        outY_q;

    logic                 adv;
    logic                 isBusy;
    logic                 issue;
    logic                 loadOut;
    logic                 handshake;
    logic                 pipeEmpty;

    // Shared control terms: the whole core pipeline advances only while the
    // output register can take (or is not holding) a result.
    always_comb begin
        adv       = !(outValid_q && !iout_ready);
        isBusy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        issue     = (state_q == ST_RUN) && iwin_rdy && adv;
        loadOut   = adv && pipeValid_q[pCORE_LAT-1];
        handshake = outValid_q && iout_ready;
        pipeEmpty = (pipeValid_q == '0);
    end

    // Next-state logic for the pass FSM and the raster position counters.
    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        case (state_q)
            ST_IDLE: begin
                if (istart) begin
                    state_d = ST_RUN;
                    ox_d    = '0;
                    oy_d    = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    if (ox_q == LAST_X) begin
                        ox_d = '0;
                        if (oy_q == LAST_Y) begin
                            oy_d    = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            oy_d = oy_q + 1'b1;
                        end
                    end else begin
                        ox_d = ox_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipeEmpty && (!outValid_q || iout_ready)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and position registers.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= ST_IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
        end
    end

    // Shadow of the core pipeline: one {valid, x, y} slot per core stage,
    // moving in lockstep with ocalc_en so bubbles stay aligned with the core.
    always_ff @(posedge iclk) begin
        if (irst) begin
            pipeValid_q <= '0;
            for (int i = 0; i < pCORE_LAT; i++) begin
                pipeX_q[i] <= '0;
                pipeY_q[i] <= '0;
            end
        end else if (adv) begin
            pipeValid_q[0] <= issue;
            pipeX_q[0]     <= ox_q;
            pipeY_q[0]     <= oy_q;
            for (int i = 1; i < pCORE_LAT; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeX_q[i]     <= pipeX_q[i-1];
                pipeY_q[i]     <= pipeY_q[i-1];
            end
        end
    end

    // Output stage: capture a real result as it leaves the core; a
    // handshake without a replacement empties the register.
    always_ff @(posedge iclk) begin
        if (irst) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outX_q     <= '0;
            outY_q     <= '0;
        end else if (loadOut) begin
            outValid_q <= 1'b1;
            outData_q  <= icore_data;
            outX_q     <= pipeX_q[pCORE_LAT-1];
            outY_q     <= pipeY_q[pCORE_LAT-1];
        end else if (handshake) begin
            outValid_q <= 1'b0;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stallCnt_q;

    // Saturating count of busy cycles frozen by downstream back-pressure;
    // restarts with each accepted pass and holds after it finishes.
    always_ff @(posedge iclk) begin
        if (irst) begin
            stallCnt_q <= '0;
        end else if ((state_q == ST_IDLE) && istart) begin
            stallCnt_q <= '0;
        end else if (isBusy && !adv && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign ostall_cnt = stallCnt_q;
`endif

    assign obusy      = isBusy;
    assign odone      = (state_q == ST_DONE);
    assign owin_req   = (state_q == ST_RUN);
    assign owin_x     = XW'(ox_q * pSTRIDE);
    assign owin_y     = YW'(oy_q * pSTRIDE);
    assign ocalc_en   = adv && isBusy;
    assign oout_valid = outValid_q;
    assign oout_data  = outData_q;
    assign oout_x     = outX_q;
    assign oout_y     = outY_q;

endmodule

// File: tb/tb_conv_mult_sched.sv
// tb_conv_mult_sched: directed bench for conv_mult_sched. Instance A runs a
// 5x5 map at stride 1, instance B a 7x7 map at stride 2; both have a 3x3
// kernel and a 3-deep core. A stand-in core returns {origin_y, origin_x} as
// nibbles so every result carries its own expected value.
`timescale 1ns/1ps
module tb_conv_mult_sched;

    localparam int LAT = 3;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic [7:0] d;
        int         cyc;
    } rec_t;

    logic       iclk = 1'b0;
    logic       irst = 1'b1;
    logic       istartA = 1'b0;
    logic       istartB = 1'b0;
    logic       iwinRdy = 1'b1;
    logic       ioutReady = 1'b1;

    logic       busyA, doneA, winReqA, calcEnA, outValidA;
    logic [2:0] winXA, winYA, outXA, outYA;
    logic [7:0] coreDataA, outDataA;
    logic       busyB, doneB, winReqB, calcEnB, outValidB;
    logic [2:0] winXB, winYB, outXB, outYB;
    logic [7:0] coreDataB, outDataB;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stallCntA, stallCntB;
`endif

    logic [7:0] coreA [LAT];
    logic [7:0] coreB [LAT];

    rec_t issueQA[$];
    rec_t resultQA[$];
    int   doneQA[$];
    rec_t issueQB[$];
    rec_t resultQB[$];
    int   doneQB[$];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    int          ib, rb, db, n;
    logic [13:0] snap;
    logic [2:0]  px, py;
    bit          holdChk;
    bit          pat [4];

    always #5 iclk = ~iclk;

    conv_mult_sched #(
        .pDATA_W(8), .pKERNEL_X(3), .pKERNEL_Y(3),
        .pIMG_W(5), .pIMG_H(5), .pSTRIDE(1), .pCORE_LAT(LAT)
    ) dutA (
        .iclk(iclk), .irst(irst), .istart(istartA),
        .obusy(busyA), .odone(doneA),
        .owin_x(winXA), .owin_y(winYA), .owin_req(winReqA),
        .iwin_rdy(iwinRdy), .ocalc_en(calcEnA), .icore_data(coreDataA),
        .oout_valid(outValidA), .iout_ready(ioutReady),
`ifdef SCHED_PERF_CNT_EN
        .ostall_cnt(stallCntA),
`endif
        .oout_data(outDataA), .oout_x(outXA), .oout_y(outYA)
    );

    conv_mult_sched #(
        .pDATA_W(8), .pKERNEL_X(3), .pKERNEL_Y(3),
        .pIMG_W(7), .pIMG_H(7), .pSTRIDE(2), .pCORE_LAT(LAT)
    ) dutB (
        .iclk(iclk), .irst(irst), .istart(istartB),
        .obusy(busyB), .odone(doneB),
        .owin_x(winXB), .owin_y(winYB), .owin_req(winReqB),
        .iwin_rdy(iwinRdy), .ocalc_en(calcEnB), .icore_data(coreDataB),
        .oout_valid(outValidB), .iout_ready(ioutReady),
`ifdef SCHED_PERF_CNT_EN
        .ostall_cnt(stallCntB),
`endif
        .oout_data(outDataB), .oout_x(outXB), .oout_y(outYB)
    );

    // Stand-in cores: a LAT-deep register chain advanced by ocalc_en.
    always @(posedge iclk) begin
        if (calcEnA) begin
            coreA[0] <= {1'b0, winYA, 1'b0, winXA};
            for (int i = 1; i < LAT; i++) coreA[i] <= coreA[i-1];
        end
        if (calcEnB) begin
            coreB[0] <= {1'b0, winYB, 1'b0, winXB};
            for (int i = 1; i < LAT; i++) coreB[i] <= coreB[i-1];
        end
    end
    assign coreDataA = coreA[LAT-1];
    assign coreDataB = coreB[LAT-1];

    // Cycle stamp used to order issues, handshakes and done pulses.
    always @(posedge iclk) cyc <= cyc + 1;

    // Mid-cycle monitors logging accepted windows, result handshakes and odone.
    always @(negedge iclk) begin
        if (winReqA && iwinRdy && calcEnA) issueQA.push_back('{x: winXA, y: winYA, d: 8'h00, cyc: cyc});
        if (outValidA && ioutReady) resultQA.push_back('{x: outXA, y: outYA, d: outDataA, cyc: cyc});
        if (doneA) doneQA.push_back(cyc);
        if (winReqB && iwinRdy && calcEnB) issueQB.push_back('{x: winXB, y: winYB, d: 8'h00, cyc: cyc});
        if (outValidB && ioutReady) resultQB.push_back('{x: outXB, y: outYB, d: outDataB, cyc: cyc});
        if (doneB) doneQB.push_back(cyc);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge iclk);
        #1;
    endtask

    task automatic applyStimulus(input bit useB);
        if (useB) istartB = 1'b1; else istartA = 1'b1;
        tick(1);
        istartA = 1'b0;
        istartB = 1'b0;
    endtask

    function automatic int doneCount(input bit useB);
        return useB ? doneQB.size() : doneQA.size();
    endfunction

    task automatic waitPassEnd(input string tag, input bit useB, input int doneBase);
        int k;
        k = 0;
        while (doneCount(useB) == doneBase && k < 200) begin
            tick(1);
            k++;
        end
        tick(3);
        checkOutput({tag, "_done_count"}, 64'(doneCount(useB) - doneBase), 64'd1);
    endtask

    // Results for a 3x3 output map in raster order; data is {origin_y, origin_x}.
    task automatic checkPass(input string tag, input bit useB, input int iBase, input int rBase, input int stride);
        rec_t r;
        int   ni, nr;
        ni = (useB ? issueQB.size() : issueQA.size()) - iBase;
        nr = (useB ? resultQB.size() : resultQA.size()) - rBase;
        checkOutput({tag, "_issue_count"}, 64'(ni), 64'd9);
        checkOutput({tag, "_result_count"}, 64'(nr), 64'd9);
        for (int k = 0; k < 9; k++) begin
            logic [2:0] ex, ey, wx, wy;
            logic [7:0] ed;
            ex = 3'(k % 3);
            ey = 3'(k / 3);
            wx = 3'((k % 3) * stride);
            wy = 3'((k / 3) * stride);
            ed = {1'b0, wy, 1'b0, wx};
            if (k < ni) begin
                r = useB ? issueQB[iBase + k] : issueQA[iBase + k];
                checkOutput({tag, "_issue_xy"}, 64'({r.x, r.y}), 64'({wx, wy}));
            end
            if (k < nr) begin
                r = useB ? resultQB[rBase + k] : resultQA[rBase + k];
                checkOutput({tag, "_result_xy"}, 64'({r.x, r.y}), 64'({ex, ey}));
                checkOutput({tag, "_result_data"}, 64'(r.d), 64'(ed));
            end
        end
    endtask

    // Directed sequence: reset, basic pass, stride 2, stall, bubbles, abort, ignored start.
    initial begin
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        $display("[TB] reset");
        tick(2);
        checkOutput("reset_outputs_A",
            64'({busyA, doneA, winReqA, calcEnA, outValidA, winXA, winYA, outXA, outYA, outDataA}), 64'd0);
        checkOutput("reset_outputs_B",
            64'({busyB, doneB, winReqB, calcEnB, outValidB, winXB, winYB, outXB, outYB, outDataB}), 64'd0);
        irst = 1'b0;
        tick(2);

        $display("[TB] basic pass 5x5 stride 1");
        ib = issueQA.size(); rb = resultQA.size(); db = doneQA.size();
        applyStimulus(1'b0);
        checkOutput("t1_busy_after_start", 64'(busyA), 64'd1);
        waitPassEnd("t1", 1'b0, db);
        checkPass("t1", 1'b0, ib, rb, 1);
        // Issue sampled in cycle t; the output register loads on the third
        // enabled edge after that cycle's edge, so it is seen in cycle t+4.
        checkOutput("t1_latency", 64'(resultQA[rb].cyc - issueQA[ib].cyc), 64'd4);
        checkOutput("t1_busy_after_done", 64'({busyA, doneA}), 64'd0);

        $display("[TB] stride 2 on 7x7");
        ib = issueQB.size(); rb = resultQB.size(); db = doneQB.size();
        applyStimulus(1'b1);
        waitPassEnd("t2", 1'b1, db);
        checkPass("t2", 1'b1, ib, rb, 2);

        $display("[TB] output stall");
        ib = issueQA.size(); rb = resultQA.size(); db = doneQA.size();
        applyStimulus(1'b0);
        n = 0;
        while (resultQA.size() - rb < 2 && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("t3_valid_before_stall", 64'(outValidA), 64'd1);
        ioutReady = 1'b0;
        #1;
        snap = {outXA, outYA, outDataA};
        for (int k = 0; k < 6; k++) begin
            checkOutput("t3_calc_en_frozen", 64'(calcEnA), 64'd0);
            checkOutput("t3_output_held", 64'({outValidA, outXA, outYA, outDataA}), 64'({1'b1, snap}));
            tick(1);
        end
        ioutReady = 1'b1;
        waitPassEnd("t3", 1'b0, db);
        checkPass("t3", 1'b0, ib, rb, 1);
`ifdef SCHED_PERF_CNT_EN
        checkOutput("t3_stall_cnt", 64'(stallCntA), 64'd6);
`endif

        $display("[TB] window-ready bubbles");
        ib = issueQA.size(); rb = resultQA.size(); db = doneQA.size();
        applyStimulus(1'b0);
        n = 0;
        while (doneQA.size() == db && n < 300) begin
            iwinRdy = pat[n % 4];
            #1;
            holdChk = !iwinRdy && winReqA;
            px = winXA;
            py = winYA;
            tick(1);
            if (holdChk) checkOutput("t4_bubble_hold", 64'({winXA, winYA}), 64'({px, py}));
            n++;
        end
        iwinRdy = 1'b1;
        tick(3);
        checkOutput("t4_done_count", 64'(doneQA.size() - db), 64'd1);
        checkPass("t4", 1'b0, ib, rb, 1);
        checkOutput("t4_done_after_last",
            64'(((doneQA.size() > db) ? doneQA[db] : -1) > resultQA[resultQA.size() - 1].cyc), 64'd1);

        $display("[TB] reset mid-pass");
        rb = resultQA.size(); db = doneQA.size();
        applyStimulus(1'b0);
        n = 0;
        while (resultQA.size() - rb < 4 && n < 100) begin
            tick(1);
            n++;
        end
        irst = 1'b1;
        tick(1);
        irst = 1'b0;
        #1;
        checkOutput("t5_outputs_zero",
            64'({busyA, doneA, winReqA, calcEnA, outValidA, winXA, winYA, outXA, outYA, outDataA}), 64'd0);
        ib = issueQA.size(); rb = resultQA.size();
        tick(20);
        checkOutput("t5_no_done", 64'(doneQA.size() - db), 64'd0);
        checkOutput("t5_no_activity", 64'({issueQA.size() - ib, resultQA.size() - rb}), 64'd0);
        checkOutput("t5_idle", 64'({busyA, winReqA}), 64'd0);
        ib = issueQA.size(); rb = resultQA.size(); db = doneQA.size();
        applyStimulus(1'b0);
        waitPassEnd("t5", 1'b0, db);
        checkPass("t5", 1'b0, ib, rb, 1);

        $display("[TB] start while busy");
        ib = issueQA.size(); rb = resultQA.size(); db = doneQA.size();
        applyStimulus(1'b0);
        tick(3);
        checkOutput("t6_busy_before_pulse", 64'(busyA), 64'd1);
        istartA = 1'b1;
        tick(1);
        istartA = 1'b0;
        waitPassEnd("t6", 1'b0, db);
        tick(10);
        checkPass("t6", 1'b0, ib, rb, 1);
        checkOutput("t6_no_restart", 64'({busyA, doneQA.size() - db}), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
